// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue buffer:
// FP opcode/funct7 constants and the stored issue entry.
package fpu_pkg;

  localparam int unsigned FLEN     = 32;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned ID_MAX_W = 16;

  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;

  // OP-FP groups whose result lands in an integer register
  localparam logic [6:0] F7_FMV_X_W  = 7'b1110000;
  localparam logic [6:0] F7_FCVT_W_S = 7'b1100000;
  localparam logic [6:0] F7_FCMP     = 7'b1010000;

  typedef struct packed {
    logic [ILEN-1:0]     instr;
    logic [ID_MAX_W-1:0] id;
    logic [XLEN-1:0]     rs1;
  } fpu_entry_t;

  function automatic logic is_fp_opcode(
    input logic [6:0] opc
  );
    logic hit;
    unique case (opc)
      OPC_LOAD_FP,
      OPC_STORE_FP,
      OPC_OP_FP,
      OPC_FMADD,
      OPC_FMSUB,
      OPC_FNMSUB,
      OPC_FNMADD: hit = 1'b1;
      default:    hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_xreg_wb(
    input logic [6:0] opc,
    input logic [6:0] f7
  );
    logic wb;
    wb = 1'b0;
    if (opc == OPC_OP_FP) begin
      unique case (1'b1)
        (f7 == F7_FMV_X_W):  wb = 1'b1;
        (f7 == F7_FCVT_W_S): wb = 1'b1;
        (f7 == F7_FCMP):     wb = 1'b1;
        default:             wb = 1'b0;
      endcase
    end
    return wb;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous circular FIFO of issue entries.
// Show-ahead read: rdata_o always presents the head slot.
module fpu_sync_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = fpu_entry_t
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  T                       wdata_i,
  output T                       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T mem_q [DEPTH];

  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wptr_d;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] rptr_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Power-of-two depth lets the pointers wrap by overflow
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop_i) begin
      rptr_d = rptr_q + PW'(1);
    end
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge ck) begin
    if (push_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fpu_issue_buffer.sv
// Decodes offered instructions and queues FP ones
// in front of the FPU model, issuing one per cycle.
module fpu_issue_buffer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [ILEN-1:0]        issue_instr,
  input  logic [X_ID_WIDTH-1:0]  issue_id,
  input  logic [XLEN-1:0]        issue_rs1,
  output logic                   resp_accept,
  output logic                   resp_writeback,
  input  logic                   fpu_full,
  output logic                   enable,
  output logic [ILEN-1:0]        instruction,
  output logic [X_ID_WIDTH-1:0]  id,
  output logic [XLEN-1:0]        data_fromXreg,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two of at least 2");
  end
  if (X_ID_WIDTH < 1 || X_ID_WIDTH > ID_MAX_W) begin : g_bad_idw
    $error("X_ID_WIDTH out of range");
  end
  if (FLEN != XLEN) begin : g_bad_flen
    $error("FMV.X.W path assumes FLEN == XLEN");
  end

  logic [CW-1:0]       count;
  logic                push;
  logic                pop;
  fpu_entry_t          wr_entry;
  fpu_entry_t          head;
  logic [ID_MAX_W-1:0] head_id_unused;

  always_comb begin
    resp_accept    = issue_valid
                   && is_fp_opcode(issue_instr[6:0]);
    resp_writeback = resp_accept
                   && is_xreg_wb(issue_instr[6:0],
                                 issue_instr[31:25]);
  end

  // Ready looks only at stored state, never at fpu_full
  assign issue_ready = !rst && (count != CW'(DEPTH));
  assign push        = issue_valid && issue_ready
                     && resp_accept;
  assign enable      = !rst && (count != '0) && !fpu_full;
  assign pop         = enable;

  always_comb begin
    wr_entry       = '0;
    wr_entry.instr = issue_instr;
    wr_entry.id    = ID_MAX_W'(issue_id);
    wr_entry.rs1   = issue_rs1;
  end

  fpu_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fpu_entry_t)
  ) u_fifo (
    .ck      (ck),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (count)
  );

  assign head_id_unused = head.id;

  always_comb begin
    instruction   = '0;
    id            = '0;
    data_fromXreg = '0;
    if (enable) begin
      instruction   = head.instr;
      id            = head.id[X_ID_WIDTH-1:0];
      data_fromXreg = head.rs1;
    end
  end

  assign occupancy = rst ? '0 : count;

endmodule

// File: tb/tb_fpu_issue_buffer.sv
// Directed bench for fpu_issue_buffer with a
// reference occupancy model and issue-order scoreboard.
module tb_fpu_issue_buffer;

  localparam int DEPTH = 4;
  localparam int IDW   = 4;

  typedef struct {
    logic [31:0]    instr;
    logic [IDW-1:0] id;
    logic [31:0]    rs1;
  } sb_t;

  logic           ck = 1'b0;
  logic           rst;
  logic           issue_valid;
  logic           issue_ready;
  logic [31:0]    issue_instr;
  logic [IDW-1:0] issue_id;
  logic [31:0]    issue_rs1;
  logic           resp_accept;
  logic           resp_writeback;
  logic           fpu_full;
  logic           enable;
  logic [31:0]    instruction;
  logic [IDW-1:0] id;
  logic [31:0]    data_fromXreg;
  logic [2:0]     occupancy;

  int  ncmp = 0;
  int  nerr = 0;
  int  occ  = 0;
  sb_t sb[$];

  logic [31:0] dec_tbl [8] = '{
    32'hC0000553, 32'hA0000553, 32'h00000553,
    32'h0000006F, 32'h00000033, 32'h00B52027,
    32'h00052087, 32'h70000553
  };
  logic [31:0] fma_tbl [5] = '{
    32'h18A5F043, 32'h18A5F047, 32'h18A5F04B,
    32'h18A5F04F, 32'h00C58053
  };

  always #5 ck = ~ck;

  fpu_issue_buffer #(
    .DEPTH      (DEPTH),
    .X_ID_WIDTH (IDW)
  ) dut (
    .ck             (ck),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_instr    (issue_instr),
    .issue_id       (issue_id),
    .issue_rs1      (issue_rs1),
    .resp_accept    (resp_accept),
    .resp_writeback (resp_writeback),
    .fpu_full       (fpu_full),
    .enable         (enable),
    .instruction    (instruction),
    .id             (id),
    .data_fromXreg  (data_fromXreg),
    .occupancy      (occupancy)
  );

  function automatic logic fp_op(input logic [6:0] o);
    return o inside {7'b0000111, 7'b0100111, 7'b1010011,
                     7'b1000011, 7'b1000111, 7'b1001011,
                     7'b1001111};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins,
                       input logic [IDW-1:0] i,
                       input logic [31:0] r);
    issue_valid = 1'b1;
    issue_instr = ins;
    issue_id    = i;
    issue_rs1   = r;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model
  task automatic tick();
    logic exp_rdy;
    logic exp_acc;
    logic exp_wb;
    logic exp_en;
    logic psh;
    sb_t  e;
    @(negedge ck);
    exp_rdy = !rst && (occ != DEPTH);
    exp_acc = issue_valid && fp_op(issue_instr[6:0]);
    exp_wb  = exp_acc && (issue_instr[6:0] == 7'b1010011)
            && (issue_instr[31:25] inside
                {7'b1110000, 7'b1100000, 7'b1010000});
    exp_en  = !rst && (occ != 0) && !fpu_full;
    chk("issue_ready", 64'(issue_ready), 64'(exp_rdy));
    chk("resp_accept", 64'(resp_accept), 64'(exp_acc));
    chk("resp_writeback", 64'(resp_writeback), 64'(exp_wb));
    chk("enable", 64'(enable), 64'(exp_en));
    chk("occupancy", 64'(occupancy),
        rst ? 64'd0 : 64'(occ));
    if (enable === 1'b1) begin
      if (sb.size() == 0) begin
        ncmp++;
        nerr++;
        $error("FAIL issue_order: observed id %h expected none",
               id);
      end else begin
        e = sb.pop_front();
        chk("instruction", 64'(instruction), 64'(e.instr));
        chk("id", 64'(id), 64'(e.id));
        chk("data_fromXreg", 64'(data_fromXreg), 64'(e.rs1));
      end
    end else begin
      chk("instruction_idle", 64'(instruction), 64'd0);
      chk("id_idle", 64'(id), 64'd0);
      chk("data_idle", 64'(data_fromXreg), 64'd0);
    end
    psh = issue_valid && exp_rdy && exp_acc;
    if (rst) begin
      occ = 0;
      sb.delete();
    end else begin
      if (psh) begin
        e.instr = issue_instr;
        e.id    = issue_id;
        e.rs1   = issue_rs1;
        sb.push_back(e);
      end
      occ = occ + int'(psh) - int'(exp_en);
    end
    @(posedge ck);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    issue_valid = 1'b0;
    issue_instr = '0;
    issue_id    = '0;
    issue_rs1   = '0;
    fpu_full    = 1'b0;
    @(posedge ck);
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();

    drive(32'h00208053, 4'd3, 32'hA5A50003);
    tick();
    idle();
    tick();
    tick();

    drive(32'h00000013, 4'd5, 32'h00000005);
    tick();
    idle();
    tick();
    tick();

    drive(32'hE0000553, 4'd6, 32'h00000006);
    tick();
    idle();
    tick();

    issue_instr = 32'h00208053;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(dec_tbl[i], IDW'(i), 32'h100 + i);
      tick();
    end
    idle();
    repeat (3) tick();
    chk("decode_drain", 64'(sb.size()), 64'd0);

    fpu_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(fma_tbl[i], IDW'(8 + i), 32'h200 + i);
      tick();
    end
    idle();
    tick();
    fpu_full = 1'b0;
    repeat (6) tick();
    chk("burst_drain", 64'(sb.size()), 64'd0);

    fpu_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(fma_tbl[i], IDW'(i), 32'h300 + i);
      tick();
    end
    fpu_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(fma_tbl[i % 5], IDW'(3 + i), 32'h400 + i);
      tick();
    end
    idle();
    repeat (5) tick();
    chk("wrap_drain", 64'(sb.size()), 64'd0);

    fpu_full = 1'b1;
    drive(32'h00208053, 4'd1, 32'h501);
    tick();
    drive(32'h00C58053, 4'd2, 32'h502);
    tick();
    idle();
    tick();
    rst      = 1'b1;
    fpu_full = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    repeat (3) tick();
    chk("reset_flush", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
